// File: rtl/bram_uart_dumper.sv
// Sweeps every RAM address and sends each word out as little-endian 8N1 bytes.
// States: IDLE wait | READ ram_en | CAPTURE latch word | START/DATA/STOP frame | NEXT advance | DONE pulse.
module bram_uart_dumper #(
  parameter int ADDR_WIDTH   = 9,
  parameter int DATA_WIDTH   = 18,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_data,
  output logic                  tx
);

  localparam int NBYTES = (DATA_WIDTH + 7) / 8;
  localparam int WORD_W = NBYTES * 8;
  localparam int CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0]  CNT_TC    = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIDX_W-1:0] BYTE_LAST = BIDX_W'(NBYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_CAPTURE, S_START, S_DATA, S_STOP, S_NEXT, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [BIDX_W-1:0]   byte_q, byte_d;
  logic [2:0]          bit_q, bit_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                en_q, en_d;
  logic                bit_tc;
  logic [7:0]          cur_byte;
  logic [2:0]          bit_nxt;

  // The word is shifted down one byte per frame, so the active byte is always the low one.
  assign cur_byte = word_q[7:0];
  assign bit_nxt  = bit_q + 3'd1;
  assign bit_tc   = (cnt_q == CNT_TC);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    word_d  = word_q;
    byte_d  = byte_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    en_d    = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_READ;
        addr_d  = '0;
        busy_d  = 1'b1;
        en_d    = 1'b1;
      end
      S_READ: state_d = S_CAPTURE;
      S_CAPTURE: begin
        word_d  = WORD_W'(ram_data);
        byte_d  = '0;
        cnt_d   = '0;
        tx_d    = 1'b0;
        state_d = S_START;
      end
      S_START: if (bit_tc) begin
        cnt_d   = '0;
        bit_d   = 3'd0;
        tx_d    = cur_byte[0];
        state_d = S_DATA;
      end else cnt_d = cnt_q + 1'b1;
      S_DATA: if (bit_tc) begin
        cnt_d = '0;
        if (bit_q == 3'd7) begin
          tx_d    = 1'b1;
          state_d = S_STOP;
        end else begin
          bit_d = bit_nxt;
          tx_d  = cur_byte[bit_nxt];
        end
      end else cnt_d = cnt_q + 1'b1;
      S_STOP: if (bit_tc) begin
        cnt_d = '0;
        if (byte_q == BYTE_LAST) state_d = S_NEXT;
        else begin
          byte_d  = byte_q + 1'b1;
          word_d  = word_q >> 8;
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end else cnt_d = cnt_q + 1'b1;
      S_NEXT: if (addr_q == '1) begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_DONE;
      end else begin
        addr_d  = addr_q + 1'b1;
        en_d    = 1'b1;
        state_d = S_READ;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      word_q  <= '0;
      byte_q  <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      byte_q  <= byte_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      en_q    <= en_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign ram_en   = en_q;
  assign ram_addr = addr_q;

endmodule

// File: tb/tb_bram_uart_dumper.sv
// Bench for bram_uart_dumper: per-cycle expected tx/en/busy/done/addr built from the frame rules.
module tb_bram_uart_dumper;

  localparam int AW_A = 3, DW_A = 18, C_A = 4, NB_A = 3, NW_A = 8;
  localparam int AW_B = 1, DW_B = 9,  C_B = 3, NB_B = 2, NW_B = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;
  logic busy_a, done_a, en_a, tx_a;
  logic busy_b, done_b, en_b, tx_b;
  logic [AW_A-1:0] addr_a;
  logic [AW_B-1:0] addr_b;
  logic [DW_A-1:0] data_a;
  logic [DW_B-1:0] data_b;
  logic [DW_A-1:0] mem_a [NW_A];
  logic [DW_B-1:0] mem_b [NW_B];

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit tx; bit en; bit busy; bit done; int addr; bit is_data;
  } exp_t;
  exp_t exp_q[$];
  int   model_words[$];

  always #5 clk = ~clk;

  always @(posedge clk) if (en_a) data_a <= mem_a[addr_a];
  always @(posedge clk) if (en_b) data_b <= mem_b[addr_b];

  bram_uart_dumper #(.ADDR_WIDTH(AW_A), .DATA_WIDTH(DW_A), .CLKS_PER_BIT(C_A)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
    .ram_en(en_a), .ram_addr(addr_a), .ram_data(data_a), .tx(tx_a));

  bram_uart_dumper #(.ADDR_WIDTH(AW_B), .DATA_WIDTH(DW_B), .CLKS_PER_BIT(C_B)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
    .ram_en(en_b), .ram_addr(addr_b), .ram_data(data_b), .tx(tx_b));

  function automatic exp_t mk(bit tx, bit en, bit busy, bit done, int addr, bit is_data);
    exp_t e;
    e.tx = tx; e.en = en; e.busy = busy; e.done = done; e.addr = addr; e.is_data = is_data;
    return e;
  endfunction

  // Expected line state for every cycle after the start-accepting edge.
  task automatic build_exp(input int nb, input int c);
    int last;
    exp_q.delete();
    last = model_words.size() - 1;
    foreach (model_words[k]) begin
      exp_q.push_back(mk(1, 1, 1, 0, k, 0));
      exp_q.push_back(mk(1, 0, 1, 0, k, 0));
      for (int b = 0; b < nb; b++) begin
        int byt;
        byt = (model_words[k] >> (8 * b)) & 255;
        repeat (c) exp_q.push_back(mk(0, 0, 1, 0, k, 0));
        for (int i = 0; i < 8; i++)
          repeat (c) exp_q.push_back(mk(bit'((byt >> i) & 1), 0, 1, 0, k, 1));
        repeat (c) exp_q.push_back(mk(1, 0, 1, 0, k, 0));
      end
      exp_q.push_back(mk(1, 0, 1, 0, k, 0));
    end
    exp_q.push_back(mk(1, 0, 0, 1, last, 0));
    exp_q.push_back(mk(1, 0, 0, 0, last, 0));
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_a = 1'b1; start_b = 1'b1;
    repeat (3) begin
      @(negedge clk);
      tests++;
      if ({tx_a, busy_a, done_a, en_a, addr_a} !== {1'b1, 3'b000, {AW_A{1'b0}}}) begin
        fails++;
        $display("FAIL reset_a: tx/busy/done/en/addr got %b%b%b%b/%0d want 1000/0", tx_a, busy_a, done_a, en_a, addr_a);
      end
      tests++;
      if ({tx_b, busy_b, done_b, en_b, addr_b} !== {1'b1, 3'b000, {AW_B{1'b0}}}) begin
        fails++;
        $display("FAIL reset_b: tx/busy/done/en/addr got %b%b%b%b/%0d want 1000/0", tx_b, busy_b, done_b, en_b, addr_b);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1; start_a = 1'b0; start_b = 1'b0;
    repeat (10) begin
      @(negedge clk);
      tests++;
      if ({tx_a, busy_a, en_a, tx_b, busy_b, en_b} !== 6'b100100) begin
        fails++;
        $display("FAIL reset_release: a tx/busy/en %b%b%b b %b%b%b want 100/100", tx_a, busy_a, en_a, tx_b, busy_b, en_b);
      end
    end
  endtask

  task automatic test_single_word();
    mem_a[0] = 18'h2A5A5;
    mem_a[1] = 18'h00001;
    for (int k = 2; k < NW_A; k++) mem_a[k] = DW_A'($urandom);
    model_words.delete();
    for (int k = 0; k < NW_A; k++) model_words.push_back(int'(mem_a[k]));
    build_exp(NB_A, C_A);
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      tests++;
      if ({tx_a, en_a, busy_a, done_a} !== {exp_q[i].tx, exp_q[i].en, exp_q[i].busy, exp_q[i].done}
          || addr_a !== AW_A'(exp_q[i].addr)) begin
        fails++;
        $display("FAIL single_word cyc %0d: tx/en/busy/done/addr got %b%b%b%b/%0d want %b%b%b%b/%0d",
                 i, tx_a, en_a, busy_a, done_a, addr_a,
                 exp_q[i].tx, exp_q[i].en, exp_q[i].busy, exp_q[i].done, exp_q[i].addr);
      end
    end
  endtask

  task automatic test_sweep_start_ignored();
    int p1, p2;
    for (int k = 0; k < NW_A; k++) mem_a[k] = DW_A'(k);
    model_words.delete();
    for (int k = 0; k < NW_A; k++) model_words.push_back(k);
    build_exp(NB_A, C_A);
    p1 = int'($urandom_range(2, exp_q.size() - 3));
    p2 = exp_q.size() - 2;
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      start_a = (i == p1 || i == p2);
      tests++;
      if ({tx_a, en_a, busy_a, done_a} !== {exp_q[i].tx, exp_q[i].en, exp_q[i].busy, exp_q[i].done}
          || addr_a !== AW_A'(exp_q[i].addr)) begin
        fails++;
        $display("FAIL sweep cyc %0d: tx/en/busy/done/addr got %b%b%b%b/%0d want %b%b%b%b/%0d",
                 i, tx_a, en_a, busy_a, done_a, addr_a,
                 exp_q[i].tx, exp_q[i].en, exp_q[i].busy, exp_q[i].done, exp_q[i].addr);
      end
    end
    start_a = 1'b0;
    repeat (20) begin
      @(negedge clk);
      tests++;
      if ({busy_a, en_a, tx_a, done_a} !== 4'b0010) begin
        fails++;
        $display("FAIL no_second_dump: busy/en/tx/done got %b%b%b%b want 0010", busy_a, en_a, tx_a, done_a);
      end
    end
  endtask

  task automatic test_reset_mid_dump();
    int  thr;
    bit  found, seen_done;
    for (int k = 0; k < NW_A; k++) mem_a[k] = DW_A'($urandom) & ~DW_A'(1);
    model_words.delete();
    for (int k = 0; k < NW_A; k++) model_words.push_back(int'(mem_a[k]));
    build_exp(NB_A, C_A);
    thr = int'($urandom_range(10, 400));
    found = 1'b0;
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      if (i >= thr && exp_q[i].is_data && !exp_q[i].tx) begin
        found = 1'b1;
        tests++;
        if (tx_a !== 1'b0) begin
          fails++;
          $display("FAIL midreset_pre: tx got %b want 0 at cyc %0d", tx_a, i);
        end
        rst_n = 1'b0;
        break;
      end
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL midreset_search: no low data bit found, got none want one");
    end
    @(posedge clk); #1;
    tests++;
    if ({tx_a, busy_a, en_a, done_a, addr_a} !== {4'b1000, {AW_A{1'b0}}}) begin
      fails++;
      $display("FAIL midreset_abort: tx/busy/en/done/addr got %b%b%b%b/%0d want 1000/0", tx_a, busy_a, en_a, done_a, addr_a);
    end
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      tests++;
      if ({tx_a, busy_a} !== 2'b10) begin
        fails++;
        $display("FAIL midreset_idle: tx/busy got %b%b want 10", tx_a, busy_a);
      end
    end
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    @(negedge clk);
    tests++;
    if ({en_a, busy_a, addr_a} !== {2'b11, {AW_A{1'b0}}}) begin
      fails++;
      $display("FAIL restart_read: en/busy/addr got %b%b/%0d want 11/0", en_a, busy_a, addr_a);
    end
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (tx_a !== 1'b0) begin
      fails++;
      $display("FAIL restart_startbit: tx got %b want 0", tx_a);
    end
    seen_done = 1'b0;
    for (int i = 0; i < 2000 && !seen_done; i++) begin
      @(negedge clk);
      if (done_a === 1'b1) seen_done = 1'b1;
    end
    tests++;
    if (!seen_done) begin
      fails++;
      $display("FAIL restart_done: done got 0 want 1 within 2000 cycles");
    end
  endtask

  task automatic test_width_padding();
    mem_b[0] = 9'h1FF;
    mem_b[1] = DW_B'($urandom);
    model_words.delete();
    for (int k = 0; k < NW_B; k++) model_words.push_back(int'(mem_b[k]));
    build_exp(NB_B, C_B);
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      tests++;
      if ({tx_b, en_b, busy_b, done_b} !== {exp_q[i].tx, exp_q[i].en, exp_q[i].busy, exp_q[i].done}
          || addr_b !== AW_B'(exp_q[i].addr)) begin
        fails++;
        $display("FAIL width_pad cyc %0d: tx/en/busy/done/addr got %b%b%b%b/%0d want %b%b%b%b/%0d",
                 i, tx_b, en_b, busy_b, done_b, addr_b,
                 exp_q[i].tx, exp_q[i].en, exp_q[i].busy, exp_q[i].done, exp_q[i].addr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_sweep_start_ignored();
    test_reset_mid_dump();
    test_width_padding();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
